// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: ALU operation codes,
// datapath widths and the multiply/divide unit state encoding.
package pipeline_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_NOR   = 4'd5,
        ALU_SLT   = 4'd6,
        ALU_SLTU  = 4'd7,
        ALU_SLL   = 4'd8,
        ALU_SRL   = 4'd9,
        ALU_SRA   = 4'd10,
        ALU_MFHI  = 4'd11,
        ALU_MFLO  = 4'd12,
        ALU_MULTU = 4'd13,
        ALU_DIVU  = 4'd14,
        ALU_RSVD  = 4'd15
    } aluc_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_mdu_op(input logic [3:0] aluc);
        return (aluc == ALU_MULTU) || (aluc == ALU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit.
// One step per cycle; HI/LO written on the final step.
module mdu_iter
    import pipeline_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(MD_CYCLES);

    mdu_state_e        state_r;
    mdu_state_e        state_nxt_s;
    logic [CW-1:0]     count_r;
    logic              op_r;
    logic [XLEN-1:0]   b_r;
    logic [XLEN-1:0]   hi_r;
    logic [XLEN-1:0]   lo_r;
    logic [2*XLEN-1:0] acc_r;
    logic [2*XLEN-1:0] acc_step_s;
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_shift_s;
    logic [XLEN:0]     div_diff_s;
    logic              last_s;

    assign last_s = (count_r == CW'(MD_CYCLES - 1));
    assign hi     = hi_r;
    assign lo     = lo_r;

    // One iteration step: acc holds {HI,LO} for multiply, {remainder,quotient} for divide.
    always_comb begin
        acc_step_s  = acc_r;
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, ({XLEN{acc_r[0]}} & b_r)};
        div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, b_r};
        if (op_r) begin
            if (!div_diff_s[XLEN]) begin
                acc_step_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_step_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Next-state and status; the start cycle itself already stalls the pipeline.
    always_comb begin
        state_nxt_s = state_r;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_r)
            MDU_IDLE: begin
                if (start && rst_n) begin
                    state_nxt_s = MDU_RUN;
                    busy        = 1'b1;
                end else begin
                    state_nxt_s = MDU_IDLE;
                end
            end
            MDU_RUN: begin
                busy = 1'b1;
                if (last_s) begin
                    state_nxt_s = MDU_DONE;
                end else begin
                    state_nxt_s = MDU_RUN;
                end
            end
            MDU_DONE: begin
                done        = 1'b1;
                state_nxt_s = MDU_IDLE;
            end
            default: begin
                state_nxt_s = MDU_IDLE;
            end
        endcase
    end

    // State, operand latch, iteration counter and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= MDU_IDLE;
            count_r <= '0;
            op_r    <= 1'b0;
            b_r     <= '0;
            acc_r   <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                MDU_IDLE: begin
                    if (start) begin
                        acc_r   <= {{XLEN{1'b0}}, a};
                        b_r     <= b;
                        op_r    <= op;
                        count_r <= '0;
                    end
                end
                MDU_RUN: begin
                    acc_r   <= acc_step_s;
                    count_r <= count_r + CW'(1);
                    if (last_s) begin
                        hi_r <= acc_step_s[2*XLEN-1:XLEN];
                        lo_r <= acc_step_s[XLEN-1:0];
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: operand muxes, ALU, MDU
// hookup, destination mux and the EXE/MEM pipeline register.
module exe_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic             ewmem,
    input  logic             eshift,
    input  logic             ealuimm,
    input  logic [3:0]       ealuc,
    input  logic [XLEN-1:0]  odata_a,
    input  logic [XLEN-1:0]  odata_b,
    input  logic [XLEN-1:0]  odata_imm,
    input  logic             e_regrt,
    input  logic [REG_W-1:0] e_rt,
    input  logic [REG_W-1:0] e_rd,
    input  logic [3:0]       EXE_ins_type,
    input  logic [3:0]       EXE_ins_number,
    output logic             stall_o,
    output logic             mwreg,
    output logic             mm2reg,
    output logic             mwmem,
    output logic [XLEN-1:0]  malu,
    output logic [XLEN-1:0]  mdata_b,
    output logic [REG_W-1:0] m_rn,
    output logic [3:0]       MEM_ins_type,
    output logic [3:0]       MEM_ins_number
);

    logic [XLEN-1:0] a_s;
    logic [XLEN-1:0] b_s;
    logic [XLEN-1:0] alu_s;
    logic [XLEN-1:0] md_hi_s;
    logic [XLEN-1:0] md_lo_s;
    logic            md_busy_s;
    logic            md_done_s;
    logic            md_start_s;

    assign a_s = eshift  ? {{(XLEN-5){1'b0}}, odata_imm[10:6]} : odata_a;
    assign b_s = ealuimm ? odata_imm : odata_b;

    // The instruction sitting in EXE during DONE is the one that just finished.
    assign md_start_s = is_mdu_op(ealuc) && !md_done_s;
    assign stall_o    = md_busy_s;

    mdu_iter #(
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start_s),
        .op    (ealuc == ALU_DIVU),
        .a     (a_s),
        .b     (b_s),
        .busy  (md_busy_s),
        .done  (md_done_s),
        .hi    (md_hi_s),
        .lo    (md_lo_s)
    );

    // Single-cycle ALU; MULTU/DIVU carry no result of their own.
    always_comb begin
        alu_s = '0;
        case (ealuc)
            ALU_ADD:   alu_s = a_s + b_s;
            ALU_SUB:   alu_s = a_s - b_s;
            ALU_AND:   alu_s = a_s & b_s;
            ALU_OR:    alu_s = a_s | b_s;
            ALU_XOR:   alu_s = a_s ^ b_s;
            ALU_NOR:   alu_s = ~(a_s | b_s);
            ALU_SLT:   alu_s = {{(XLEN-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
            ALU_SLTU:  alu_s = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLL:   alu_s = b_s << a_s[4:0];
            ALU_SRL:   alu_s = b_s >> a_s[4:0];
            ALU_SRA:   alu_s = XLEN'($signed(b_s) >>> a_s[4:0]);
            ALU_MFHI:  alu_s = md_hi_s;
            ALU_MFLO:  alu_s = md_lo_s;
            ALU_MULTU: alu_s = '0;
            ALU_DIVU:  alu_s = '0;
            ALU_RSVD:  alu_s = a_s + b_s;
            default:   alu_s = a_s + b_s;
        endcase
    end

    // EXE/MEM register; a stalled cycle pushes a bubble toward MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mwreg          <= 1'b0;
            mm2reg         <= 1'b0;
            mwmem          <= 1'b0;
            malu           <= '0;
            mdata_b        <= '0;
            m_rn           <= '0;
            MEM_ins_type   <= 4'd0;
            MEM_ins_number <= 4'd0;
        end else if (stall_o) begin
            mwreg          <= 1'b0;
            mm2reg         <= 1'b0;
            mwmem          <= 1'b0;
            malu           <= '0;
            mdata_b        <= '0;
            m_rn           <= '0;
            MEM_ins_type   <= 4'd0;
            MEM_ins_number <= 4'd0;
        end else begin
            mwreg          <= ewreg;
            mm2reg         <= em2reg;
            mwmem          <= ewmem;
            malu           <= alu_s;
            mdata_b        <= odata_b;
            m_rn           <= e_regrt ? e_rt : e_rd;
            MEM_ins_type   <= EXE_ins_type;
            MEM_ins_number <= EXE_ins_number;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Randomized self-checking bench for exe_stage against an arithmetic model.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ewreg, em2reg, ewmem, eshift, ealuimm, e_regrt;
    logic [3:0]  ealuc;
    logic [31:0] odata_a, odata_b, odata_imm;
    logic [4:0]  e_rt, e_rd;
    logic [3:0]  EXE_ins_type, EXE_ins_number;
    logic        stall_o, mwreg, mm2reg, mwmem;
    logic [31:0] malu, mdata_b;
    logic [4:0]  m_rn;
    logic [3:0]  MEM_ins_type, MEM_ins_number;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    always #5 clk = ~clk;

    exe_stage #(.XLEN(32), .MD_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .eshift(eshift), .ealuimm(ealuimm), .ealuc(ealuc), .odata_a(odata_a),
        .odata_b(odata_b), .odata_imm(odata_imm), .e_regrt(e_regrt), .e_rt(e_rt),
        .e_rd(e_rd), .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number),
        .stall_o(stall_o), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mdata_b(mdata_b), .m_rn(m_rn), .MEM_ins_type(MEM_ins_type),
        .MEM_ins_number(MEM_ins_number)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] aluc, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic sh, input logic ai,
                          input logic rgt, input logic wr, input logic m2r, input logic wm,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [3:0] ty, input logic [3:0] num);
        ealuc = aluc; odata_a = a; odata_b = b; odata_imm = imm;
        eshift = sh; ealuimm = ai; e_regrt = rgt; ewreg = wr; em2reg = m2r; ewmem = wm;
        e_rt = rt; e_rd = rd; EXE_ins_type = ty; EXE_ins_number = num;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0, 4'd15: return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b << a[4:0];
            4'd9:  return b >> a[4:0];
            4'd10: return 32'($signed(b) >>> a[4:0]);
            4'd11: return hi_m;
            4'd12: return lo_m;
            default: return 32'd0;
        endcase
    endfunction

    // Issue the instruction already on the inputs (called #1 after a rising edge).
    task automatic do_op(input string tag);
        logic [31:0] a_eff, b_eff, exp_alu;
        logic [4:0]  exp_rn;
        logic [63:0] prod;
        int          n;
        a_eff   = eshift ? {27'd0, odata_imm[10:6]} : odata_a;
        b_eff   = ealuimm ? odata_imm : odata_b;
        exp_rn  = e_regrt ? e_rt : e_rd;
        exp_alu = 32'd0;
        if (ealuc == 4'd13 || ealuc == 4'd14) begin
            n = 0;
            while (n < 100) begin
                @(negedge clk);
                if (!stall_o) break;
                n++;
                if (n > 1) begin
                    check_eq({tag, "_bubble_ctl"},
                             64'({mwreg, mm2reg, mwmem, m_rn, MEM_ins_type, MEM_ins_number}), 64'd0);
                    check_eq({tag, "_bubble_dat"}, {malu, mdata_b}, 64'd0);
                end
            end
            check_eq({tag, "_stall_len"}, 64'(n), 64'd33);
            if (ealuc == 4'd13) begin
                prod = 64'(a_eff) * 64'(b_eff);
                hi_m = prod[63:32];
                lo_m = prod[31:0];
            end else if (b_eff == 32'd0) begin
                hi_m = a_eff;
                lo_m = 32'hFFFF_FFFF;
            end else begin
                hi_m = a_eff % b_eff;
                lo_m = a_eff / b_eff;
            end
            @(posedge clk); #1;
        end else begin
            exp_alu = ref_alu(ealuc, a_eff, b_eff);
            @(negedge clk);
            check_eq({tag, "_stall"}, 64'(stall_o), 64'd0);
            @(posedge clk); #1;
            check_eq({tag, "_malu"}, 64'(malu), 64'(exp_alu));
        end
        check_eq({tag, "_ctl"}, 64'({mwreg, mm2reg, mwmem}), 64'({ewreg, em2reg, ewmem}));
        check_eq({tag, "_rn"}, 64'(m_rn), 64'(exp_rn));
        check_eq({tag, "_datab"}, 64'(mdata_b), 64'(odata_b));
        check_eq({tag, "_tags"}, 64'({MEM_ins_type, MEM_ins_number}),
                 64'({EXE_ins_type, EXE_ins_number}));
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        set_in(4'd11, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd8, 4'd2, 4'd1);
        do_op({tag, "_mfhi"});
        check_eq({tag, "_hi"}, 64'(malu), 64'(exp_hi));
        set_in(4'd12, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd9, 4'd2, 4'd2);
        do_op({tag, "_mflo"});
        check_eq({tag, "_lo"}, 64'(malu), 64'(exp_lo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        rst_n = 1'b0;
        set_in(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 4'd0, 4'd0);
        #12;
        check_eq("reset_stall", 64'(stall_o), 64'd0);
        check_eq("reset_ctl", 64'({mwreg, mm2reg, mwmem, m_rn, MEM_ins_type, MEM_ins_number}), 64'd0);
        check_eq("reset_dat", {malu, mdata_b}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        set_in(4'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd5, 4'd1, 4'd1);
        do_op("add_wrap");
        check_eq("add_wrap_val", 64'(malu), 64'h8000_0000);
        set_in(4'd10, 32'd0, 32'hF000_0000, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 5'd2, 4'd1, 4'd2);
        do_op("sra");
        check_eq("sra_val", 64'(malu), 64'hFF00_0000);
        set_in(4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 4'd1, 4'd3);
        do_op("slt");
        check_eq("slt_val", 64'(malu), 64'd1);
        set_in(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 4'd1, 4'd4);
        do_op("sltu");
        check_eq("sltu_val", 64'(malu), 64'd0);

        set_in(4'd13, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 4'd3, 4'd5);
        do_op("multu");
        read_hilo("multu", 32'd1, 32'hFFFF_FFFE);
        set_in(4'd14, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 4'd3, 4'd6);
        do_op("divu");
        read_hilo("divu", 32'd2, 32'd14);
        set_in(4'd14, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 4'd3, 4'd7);
        do_op("divu0");
        read_hilo("divu0", 32'd9, 32'hFFFF_FFFF);

        // Reset while a MULTU is at iteration 10.
        set_in(4'd13, 32'h1234_5678, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 4'd3, 4'd8);
        for (int i = 0; i < 12; i++) @(negedge clk);
        check_eq("midrst_pre_stall", 64'(stall_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_stall", 64'(stall_o), 64'd0);
        check_eq("midrst_ctl", 64'({mwreg, mm2reg, mwmem, m_rn, MEM_ins_type, MEM_ins_number}), 64'd0);
        check_eq("midrst_dat", {malu, mdata_b}, 64'd0);
        hi_m = 32'd0;
        lo_m = 32'd0;
        set_in(4'd0, 32'd40, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 4'd1, 4'd9);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("post_rst_add");
        check_eq("post_rst_add_val", 64'(malu), 64'd42);
        read_hilo("post_rst", 32'd0, 32'd0);

        set_in(4'd14, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 4'd3, 4'd10);
        do_op("b2b_div1");
        set_in(4'd14, 32'd77, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 4'd3, 4'd11);
        do_op("b2b_div2");
        read_hilo("b2b", 32'd2, 32'd15);

        for (int i = 0; i < 48; i++) begin
            if (i % 8 == 7) begin
                op = ($urandom_range(0, 1) == 0) ? 4'd13 : 4'd14;
                set_in(op, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom,
                       1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0,
                       5'($urandom), 5'($urandom), 4'($urandom), 4'($urandom));
                do_op("rnd_md");
            end else begin
                op = 4'($urandom_range(0, 13));
                if (op == 4'd13) op = 4'd15;
                set_in(op, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       5'($urandom), 5'($urandom), 4'($urandom), 4'($urandom));
                do_op("rnd_alu");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage plus EXE/MEM pipeline register for the 5-stage MIPS pipeline.
- Consumes the ID/EXE register outputs: control bits, aluc, operands, immediate, rt/rd and trace tags.
- Performs ALU/shift operations and iterative unsigned multiply/divide into HI/LO.
- Raises a stall to upstream while a multiply/divide runs, and registers results toward MEM.

Parameters:
- XLEN, 32, datapath width
- MD_CYCLES, 32, multiply/divide iterations; must equal XLEN

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ewreg  in  1  register write enable from ID/EXE
- em2reg  in  1  load writeback select
- ewmem  in  1  memory write enable
- eshift  in  1  A operand = odata_imm[10:6] zero-extended
- ealuimm  in  1  B operand = odata_imm
- ealuc  in  4  operation code (pipeline_pkg)
- odata_a, odata_b, odata_imm  in  32 each  operands / sign-extended immediate
- e_regrt  in  1  1: destination = e_rt, 0: destination = e_rd
- e_rt, e_rd  in  5 each  register numbers
- EXE_ins_type, EXE_ins_number  in  4 each  trace tags
- stall_o  out  1  hold PC, IF/ID and ID/EXE this cycle
- mwreg, mm2reg, mwmem  out  1 each  registered control to MEM
- malu  out  32  registered ALU result
- mdata_b  out  32  registered store data (odata_b)
- m_rn  out  5  registered destination register
- MEM_ins_type, MEM_ins_number  out  4 each  registered trace tags

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, HI=LO=0, MDU state IDLE, iteration count 0.
- Operand selection: A = eshift ? {27'b0, odata_imm[10:6]} : odata_a; B = ealuimm ? odata_imm : odata_b.
- aluc codes:
  - 0 ADD, 1 SUB (wrap-around, no overflow trap), 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed, result 0/1), 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA: B shifted by A[4:0]
  - 11 MFHI, 12 MFLO: result = HI / LO
  - 13 MULTU, 14 DIVU
  - 15 reserved, behaves as ADD
- Non-MDU ops: single cycle; result registered into malu at the next edge.
- Register update when stall_o=0: all EXE/MEM outputs take their inputs, with m_rn = e_regrt ? e_rt : e_rd.
- Register update when stall_o=1: EXE/MEM loads a bubble (mwreg=mwmem=mm2reg=0, malu=0, mdata_b=0, m_rn=0; tags 0).
- MDU FSM (sub-module), states IDLE, RUN, DONE:
  - IDLE: if ealuc is 13/14, latch A/B, clear count, go RUN; stall_o=1 this cycle.
  - RUN: one shift-add (MULTU) or restoring-subtract (DIVU) step per cycle; stall_o=1.
  - RUN at count=MD_CYCLES-1: final step, write HI/LO at that edge, go DONE.
  - DONE: stall_o=0; the MDU instruction advances; go IDLE. It reaches EXE/MEM with its control bits; decode guarantees ewreg=0 for it.
  - MDU start is never taken in DONE, so the same instruction cannot retrigger.
- Latency: stall_o high for exactly MD_CYCLES+1 consecutive cycles per MDU op; HI/LO visible to MFHI/MFLO in the DONE cycle and after.
- MULTU: {HI,LO} = A*B (64-bit unsigned).
- DIVU: LO = A/B, HI = A%B.
- DIVU by zero: LO=32'hFFFFFFFF, HI=A (natural restoring result, no trap).
- HI/LO unchanged by any non-MDU op.
- Reset mid-operation: FSM to IDLE, HI/LO cleared, stall_o drops immediately (combinational from state).

Decomposition:
- pipeline_pkg: aluc code constants (ALU_ADD..ALU_DIVU), XLEN, register-number width, MDU state encoding.
- Sub-module mdu_iter:
  - Inputs: clk, rst_n, start, op, a, b.
  - Outputs: busy, done, hi, lo.
  - Holds the FSM, counter and 64-bit shift register.
- exe_stage holds the ALU, operand muxes, destination mux and EXE/MEM register.

Test Plan:
- ADD A=32'h7FFFFFFF B=1, e_regrt=0 e_rd=5 ewreg=1 -> next edge malu=32'h80000000, m_rn=5, mwreg=1, stall_o=0.
- SRA eshift=1 imm[10:6]=4, odata_b=32'hF0000000 -> malu=32'hFF000000; SLT A=-1 B=1 -> 1; SLTU same -> 0.
- MULTU A=32'hFFFFFFFF B=2 -> stall_o high 33 cycles, bubbles on EXE/MEM during stall; following MFHI malu=1, MFLO malu=32'hFFFFFFFE.
- DIVU A=100 B=7 -> LO=14, HI=2; DIVU A=9 B=0 -> LO=32'hFFFFFFFF, HI=9.
- Assert rst_n low at RUN count 10 of a MULTU -> immediately stall_o=0, all outputs 0, HI/LO=0; after release a new ADD completes in 1 cycle.
- Back-to-back DIVU, DIVU -> two separate 33-cycle stalls, no retrigger gap error; second result overwrites HI/LO.
